// File: rtl/rename_ctrl_pkg.sv
// Shared definitions for the rename-stage controller: FSM states and default
// resource depths.
package rename_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam int DEF_ROB_DEPTH      = 32;
  localparam int DEF_PREG_FREE      = 32;
  localparam int DEF_LSQ_DEPTH      = 16;
  localparam int DEF_RECOVER_CYCLES = 4;

endpackage

// File: rtl/rename_ctrl_credit_counter.sv
// Free-entry credit counter: +1 per free, -1 per alloc, saturating at MAX with a
// sticky overflow flag when a free arrives while already full.
module credit_counter
  import rename_ctrl_pkg::*;
#(
  parameter int MAX = DEF_ROB_DEPTH,
  parameter int W   = $clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_alloc,
  input  logic         i_free,
  output logic [W-1:0] o_count,
  output logic         o_overflow
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_count;
  logic         r_overflow;

  // The owner never allocates at zero credits, so only the top end needs guarding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= MAX_V;
      r_overflow <= 1'b0;
    end else if (i_free && !i_alloc) begin
      if (r_count == MAX_V) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else if (i_alloc && !i_free) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/rename_ctrl.sv
// Rename-stage flow control: gates the decode-rename slot on ROB/PREG/LSQ credits
// and sequences the flush/recover window after a branch mispredict.
module rename_ctrl
  import rename_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH      = DEF_ROB_DEPTH,
  parameter int PREG_FREE      = DEF_PREG_FREE,
  parameter int LSQ_DEPTH      = DEF_LSQ_DEPTH,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_d,
  input  logic                         reg_write_r,
  input  logic [4:0]                   rd_r,
  input  logic                         mem_read_r,
  input  logic                         mem_write_r,
  input  logic                         rob_free,
  input  logic                         preg_free,
  input  logic                         lsq_free,
  input  logic                         mispredict,
  output logic                         hold_dr,
  output logic                         valid_r,
  output logic                         rename_fire,
  output logic                         alloc_preg,
  output logic                         alloc_lsq,
  output logic                         flush_dr,
  output logic [$clog2(ROB_DEPTH):0]   rob_credits,
  output logic [$clog2(PREG_FREE):0]   preg_credits,
  output logic [$clog2(LSQ_DEPTH):0]   lsq_credits,
  output logic [31:0]                  stall_cycles,
  output logic                         credit_err
);

  localparam int             RCW          = $clog2(RECOVER_CYCLES) + 1;
  localparam logic [RCW-1:0] LAST_RECOVER = RCW'(RECOVER_CYCLES - 1);

  state_e         r_state;
  state_e         w_nextState;
  logic [RCW-1:0] r_recoverCnt;
  logic [RCW-1:0] w_nextRecoverCnt;
  logic           r_valid;
  logic           w_nextValid;
  logic [31:0]    r_stallCycles;
  logic           w_needPreg;
  logic           w_needLsq;
  logic           w_fire;
  logic           w_hold;
  logic           w_robOvf;
  logic           w_pregOvf;
  logic           w_lsqOvf;

  assign w_needPreg = reg_write_r && (rd_r != 5'd0);
  assign w_needLsq  = mem_read_r || mem_write_r;

  // A mispredict squashes the slot in the same cycle, so it also blocks the fire.
  always_comb begin
    w_fire = (r_state == RUN) && r_valid && !mispredict && (rob_credits != '0) &&
             (!w_needPreg || (preg_credits != '0)) &&
             (!w_needLsq || (lsq_credits != '0));
    w_hold = (r_state != RUN) || (r_valid && !w_fire);
  end

  always_comb begin
    w_nextState      = r_state;
    w_nextRecoverCnt = r_recoverCnt;
    if (mispredict) begin
      w_nextState      = FLUSH;
      w_nextRecoverCnt = '0;
    end else begin
      case (r_state)
        RUN: ;
        FLUSH: begin
          w_nextState      = RECOVER;
          w_nextRecoverCnt = '0;
        end
        RECOVER: begin
          if (r_recoverCnt == LAST_RECOVER) begin
            w_nextState = RUN;
          end else begin
            w_nextRecoverCnt = r_recoverCnt + 1'b1;
          end
        end
        default: w_nextState = RUN;
      endcase
    end
  end

  always_comb begin
    w_nextValid = r_valid;
    if (mispredict || (r_state != RUN)) begin
      w_nextValid = 1'b0;
    end else if (!w_hold) begin
      w_nextValid = valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_recoverCnt  <= '0;
      r_valid       <= 1'b0;
      r_stallCycles <= '0;
    end else begin
      r_state      <= w_nextState;
      r_recoverCnt <= w_nextRecoverCnt;
      r_valid      <= w_nextValid;
      if (r_valid && !w_fire) begin
        r_stallCycles <= r_stallCycles + 32'd1;
      end
    end
  end

  credit_counter #(.MAX(ROB_DEPTH)) u_robCredits (
    .clk        (clk),
    .reset      (reset),
    .i_alloc    (w_fire),
    .i_free     (rob_free),
    .o_count    (rob_credits),
    .o_overflow (w_robOvf)
  );

  credit_counter #(.MAX(PREG_FREE)) u_pregCredits (
    .clk        (clk),
    .reset      (reset),
    .i_alloc    (w_fire && w_needPreg),
    .i_free     (preg_free),
    .o_count    (preg_credits),
    .o_overflow (w_pregOvf)
  );

  credit_counter #(.MAX(LSQ_DEPTH)) u_lsqCredits (
    .clk        (clk),
    .reset      (reset),
    .i_alloc    (w_fire && w_needLsq),
    .i_free     (lsq_free),
    .o_count    (lsq_credits),
    .o_overflow (w_lsqOvf)
  );

  assign rename_fire  = w_fire;
  assign alloc_preg   = w_fire && w_needPreg;
  assign alloc_lsq    = w_fire && w_needLsq;
  assign hold_dr      = w_hold;
  assign valid_r      = r_valid;
  assign flush_dr     = (r_state == FLUSH);
  assign stall_cycles = r_stallCycles;
  assign credit_err   = w_robOvf || w_pregOvf || w_lsqOvf;

endmodule

// File: tb/tb_rename_ctrl.sv
// Bench for rename_ctrl: directed scenarios plus a randomized run, all checked
// against a cycle-level behavioural model of slot, flush window and credit pools.
module tb_rename_ctrl;

  localparam int ROB  = 32;
  localparam int PREG = 32;
  localparam int LSQ  = 16;
  localparam int RC   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_d = 1'b0, reg_write_r = 1'b0, mem_read_r = 1'b0, mem_write_r = 1'b0;
  logic [4:0]  rd_r = 5'd0;
  logic        rob_free = 1'b0, preg_free = 1'b0, lsq_free = 1'b0, mispredict = 1'b0;
  logic        hold_dr, valid_r, rename_fire, alloc_preg, alloc_lsq, flush_dr, credit_err;
  logic [5:0]  rob_credits;
  logic [5:0]  preg_credits;
  logic [4:0]  lsq_credits;
  logic [31:0] stall_cycles;

  int nChecks = 0;
  int nPass = 0;

  // Model: slot occupancy, cycles left in the flush+recover window, credit pools.
  bit        m_valid;
  int        m_window;
  int        m_rob, m_preg, m_lsq;
  bit [31:0] m_stall;
  bit        m_err;

  rename_ctrl #(.ROB_DEPTH(ROB), .PREG_FREE(PREG), .LSQ_DEPTH(LSQ), .RECOVER_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .reg_write_r(reg_write_r), .rd_r(rd_r),
    .mem_read_r(mem_read_r), .mem_write_r(mem_write_r), .rob_free(rob_free),
    .preg_free(preg_free), .lsq_free(lsq_free), .mispredict(mispredict),
    .hold_dr(hold_dr), .valid_r(valid_r), .rename_fire(rename_fire), .alloc_preg(alloc_preg),
    .alloc_lsq(alloc_lsq), .flush_dr(flush_dr), .rob_credits(rob_credits),
    .preg_credits(preg_credits), .lsq_credits(lsq_credits), .stall_cycles(stall_cycles),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit m_needPreg();
    return reg_write_r && (rd_r != 5'd0);
  endfunction

  function automatic bit m_needLsq();
    return mem_read_r || mem_write_r;
  endfunction

  function automatic bit m_fire();
    return (m_window == 0) && m_valid && !mispredict && (m_rob > 0) &&
           (!m_needPreg() || m_preg > 0) && (!m_needLsq() || m_lsq > 0);
  endfunction

  function automatic bit m_hold();
    return (m_window != 0) || (m_valid && !m_fire());
  endfunction

  // Advance model and DUT across one rising edge; returns at the next falling edge.
  task automatic tick();
    bit        f;
    bit        nv, ne;
    int        nw, nr, np, nl;
    bit [31:0] ns;
    f = m_fire();
    if (reset) begin
      nv = 0; nw = 0; nr = ROB; np = PREG; nl = LSQ; ns = '0; ne = 0;
    end else begin
      ns = m_stall + ((m_valid && !f) ? 32'd1 : 32'd0);
      nv = (mispredict || m_window != 0) ? 1'b0 : (m_hold() ? m_valid : valid_d);
      nw = mispredict ? RC + 1 : (m_window > 0 ? m_window - 1 : 0);
      ne = m_err;
      nr = m_rob + int'(rob_free) - int'(f);
      np = m_preg + int'(preg_free) - int'(f && m_needPreg());
      nl = m_lsq + int'(lsq_free) - int'(f && m_needLsq());
      if (nr > ROB) begin nr = ROB; ne = 1; end
      if (np > PREG) begin np = PREG; ne = 1; end
      if (nl > LSQ) begin nl = LSQ; ne = 1; end
    end
    @(posedge clk);
    m_valid = nv; m_window = nw; m_rob = nr; m_preg = np; m_lsq = nl; m_stall = ns; m_err = ne;
    @(negedge clk);
  endtask

  task automatic set_idle();
    reset = 0; valid_d = 0; reg_write_r = 0; rd_r = 0; mem_read_r = 0; mem_write_r = 0;
    rob_free = 0; preg_free = 0; lsq_free = 0; mispredict = 0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    nChecks++;
    if ({hold_dr, rename_fire, flush_dr, valid_r} !== 4'b0000) begin
      $display("[TB] FAIL reset_outs: got %b want 0000", {hold_dr, rename_fire, flush_dr, valid_r});
    end else nPass++;
    nChecks++;
    if ({rob_credits, preg_credits, lsq_credits} !== {6'd32, 6'd32, 5'd16}) begin
      $display("[TB] FAIL reset_credits: got %0d/%0d/%0d want 32/32/16", rob_credits, preg_credits, lsq_credits);
    end else nPass++;
    nChecks++;
    if (stall_cycles !== 32'd0 || credit_err !== 1'b0) begin
      $display("[TB] FAIL reset_stall_err: got %0d/%b want 0/0", stall_cycles, credit_err);
    end else nPass++;
    tick();
  endtask

  task automatic test_fire_stream();
    int expPreg;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      valid_d = 1; reg_write_r = 1; rd_r = 5;
      #1;
      expPreg = (i >= 2) ? PREG - (i - 1) : PREG;
      nChecks++;
      if (rename_fire !== (i >= 1) || alloc_preg !== (i >= 1)) begin
        $display("[TB] FAIL stream_fire[%0d]: got %b/%b want %b", i, rename_fire, alloc_preg, i >= 1);
      end else nPass++;
      nChecks++;
      if (int'(preg_credits) !== expPreg) begin
        $display("[TB] FAIL stream_preg[%0d]: got %0d want %0d", i, preg_credits, expPreg);
      end else nPass++;
      tick();
    end
  endtask

  task automatic test_preg_drain();
    bit [31:0] s0;
    int k;
    do_reset();
    for (k = 0; k < 100; k++) begin
      valid_d = 1; reg_write_r = 1; rd_r = 3; rob_free = 0;
      #1;
      if (m_preg == 0) break;
      rob_free = m_fire();
      tick();
    end
    nChecks++;
    if (k == 100 || preg_credits !== 6'd0) begin
      $display("[TB] FAIL drain_preg: got %0d after %0d cycles want 0", preg_credits, k);
    end else nPass++;
    s0 = m_stall;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) #1;
      nChecks++;
      if (rename_fire !== 1'b0 || hold_dr !== 1'b1 || stall_cycles !== s0 + j) begin
        $display("[TB] FAIL drain_stall[%0d]: got fire=%b hold=%b stall=%0d want 0/1/%0d",
                 j, rename_fire, hold_dr, stall_cycles, s0 + j);
      end else nPass++;
      tick();
    end
    preg_free = 1;
    tick();
    preg_free = 0;
    #1;
    nChecks++;
    if (rename_fire !== 1'b1 || alloc_preg !== 1'b1 || preg_credits !== 6'd1) begin
      $display("[TB] FAIL drain_refire: got fire=%b alloc=%b preg=%0d want 1/1/1",
               rename_fire, alloc_preg, preg_credits);
    end else nPass++;
    rob_free = 1;
    tick();
    rob_free = 0; rd_r = 0;
    #1;
    nChecks++;
    if (preg_credits !== 6'd0) begin
      $display("[TB] FAIL drain_zero: got %0d want 0", preg_credits);
    end else nPass++;
    nChecks++;
    if (rename_fire !== 1'b1 || alloc_preg !== 1'b0) begin
      $display("[TB] FAIL rd0_fire: got fire=%b alloc=%b want 1/0", rename_fire, alloc_preg);
    end else nPass++;
    tick();
  endtask

  task automatic test_mispredict();
    do_reset();
    valid_d = 1; reg_write_r = 1; rd_r = 7;
    tick();
    tick();
    mispredict = 1;
    #1;
    nChecks++;
    if (rename_fire !== 1'b0 || valid_r !== 1'b1) begin
      $display("[TB] FAIL misp_fire: got fire=%b valid=%b want 0/1", rename_fire, valid_r);
    end else nPass++;
    tick();
    mispredict = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      nChecks++;
      if (flush_dr !== (k == 0) || hold_dr !== 1'b1 || valid_r !== 1'b0) begin
        $display("[TB] FAIL misp_window[%0d]: got flush=%b hold=%b valid=%b want %b/1/0",
                 k, flush_dr, hold_dr, valid_r, k == 0);
      end else nPass++;
      tick();
    end
    #1;
    nChecks++;
    if (hold_dr !== 1'b0 || flush_dr !== 1'b0) begin
      $display("[TB] FAIL misp_run: got hold=%b flush=%b want 0/0", hold_dr, flush_dr);
    end else nPass++;
    tick();
    mispredict = 1;
    tick();
    mispredict = 0;
    tick();
    tick();
    mispredict = 1;
    tick();
    mispredict = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      nChecks++;
      if (flush_dr !== (k == 0) || hold_dr !== 1'b1) begin
        $display("[TB] FAIL remisp_window[%0d]: got flush=%b hold=%b want %b/1", k, flush_dr, hold_dr, k == 0);
      end else nPass++;
      tick();
    end
    #1;
    nChecks++;
    if (hold_dr !== 1'b0 || flush_dr !== 1'b0 || rob_credits !== 6'(m_rob)) begin
      $display("[TB] FAIL remisp_run: got hold=%b flush=%b rob=%0d want 0/0/%0d", hold_dr, flush_dr, rob_credits, m_rob);
    end else nPass++;
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    rob_free = 1;
    tick();
    rob_free = 0;
    #1;
    nChecks++;
    if (rob_credits !== 6'd32 || credit_err !== 1'b1) begin
      $display("[TB] FAIL ovf_set: got rob=%0d err=%b want 32/1", rob_credits, credit_err);
    end else nPass++;
    tick();
    tick();
    tick();
    nChecks++;
    if (credit_err !== 1'b1) begin
      $display("[TB] FAIL ovf_sticky: got %b want 1", credit_err);
    end else nPass++;
    do_reset();
    #1;
    nChecks++;
    if (credit_err !== 1'b0) begin
      $display("[TB] FAIL ovf_clear: got %b want 0", credit_err);
    end else nPass++;
    tick();
  endtask

  task automatic test_lsq_same_cycle();
    int k;
    do_reset();
    for (k = 0; k < 50; k++) begin
      valid_d = 1; mem_read_r = 1; reg_write_r = 0; rob_free = 0;
      #1;
      if (m_lsq == 7) break;
      rob_free = m_fire();
      tick();
    end
    lsq_free = 1; rob_free = 1;
    nChecks++;
    if (k == 50 || rename_fire !== 1'b1 || alloc_lsq !== 1'b1 || lsq_credits !== 5'd7) begin
      $display("[TB] FAIL lsq_setup: got fire=%b alloc=%b lsq=%0d want 1/1/7", rename_fire, alloc_lsq, lsq_credits);
    end else nPass++;
    tick();
    set_idle();
    #1;
    nChecks++;
    if (lsq_credits !== 5'd7 || credit_err !== 1'b0) begin
      $display("[TB] FAIL lsq_same_cycle: got lsq=%0d err=%b want 7/0", lsq_credits, credit_err);
    end else nPass++;
    tick();
  endtask

  task automatic test_random();
    logic [6:0] expBits;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(99) < 1);
      valid_d     = ($urandom_range(99) < 70);
      reg_write_r = ($urandom_range(99) < 50);
      rd_r        = 5'($urandom_range(31));
      mem_read_r  = ($urandom_range(99) < 20);
      mem_write_r = ($urandom_range(99) < 20);
      rob_free    = ($urandom_range(99) < 30);
      preg_free   = ($urandom_range(99) < 25);
      lsq_free    = ($urandom_range(99) < 15);
      mispredict  = ($urandom_range(99) < 3);
      #1;
      expBits = {m_fire(), m_fire() && m_needPreg(), m_fire() && m_needLsq(), m_hold(),
                 m_window == RC + 1, m_valid, m_err};
      nChecks++;
      if ({rename_fire, alloc_preg, alloc_lsq, hold_dr, flush_dr, valid_r, credit_err} !== expBits) begin
        $display("[TB] FAIL rand_ctrl[%0d]: got fire,ap,al,hold,flush,valid,err=%b want %b", c,
                 {rename_fire, alloc_preg, alloc_lsq, hold_dr, flush_dr, valid_r, credit_err}, expBits);
      end else nPass++;
      nChecks++;
      if (int'(rob_credits) !== m_rob || int'(preg_credits) !== m_preg || int'(lsq_credits) !== m_lsq) begin
        $display("[TB] FAIL rand_credits[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                 rob_credits, preg_credits, lsq_credits, m_rob, m_preg, m_lsq);
      end else nPass++;
      nChecks++;
      if (stall_cycles !== m_stall) begin
        $display("[TB] FAIL rand_stall[%0d]: got %0d want %0d", c, stall_cycles, m_stall);
      end else nPass++;
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fire_stream();
    test_preg_drain();
    test_mispredict();
    test_overflow();
    test_lsq_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
